// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
//
// Program-counter sequencer for the CPU fetch path. Holds the current
// instruction address and, on every enabled cycle, increments it, jumps to an
// absolute target, branches by a signed offset, or calls/returns through a
// small hardware return stack. The pc output feeds the instruction-fetch
// register stage directly.
//
// Configuration macro:
//   PC_STACK_EN  defined   -> return stack present; CALL pushes pc+1 and jumps,
//                             RET pops into pc; overflow/underflow raise stack_err.
//                undefined -> no stack storage; CALL acts as JMP (no error),
//                             RET acts as INC and raises stack_err;
//                             stack_full tied 0, stack_empty tied 1.
//
// Parameters:
//   ADDR_W       address width in bits
//   STACK_DEPTH  return-stack entries (power of two, >= 2)
//   RESET_ADDR   pc value after reset
//
// Ports:
//   clk          in   rising-edge clock
//   clr          in   asynchronous active-low reset (low = clear)
//   en           in   advance enable; 0 holds all state
//   op[2:0]      in   000 HOLD, 001 INC, 010 JMP, 011 BR, 100 CALL, 101 RET,
//                     110/111 behave as INC
//   target       in   JMP/CALL absolute address, BR two's-complement offset
//   pc           out  current instruction address (registered)
//   stack_full   out  return stack holds STACK_DEPTH entries (registered)
//   stack_empty  out  return stack holds no entries (registered)
//   stack_err    out  one-cycle pulse after CALL-when-full or RET-when-empty
//
// All outputs come straight from flops; op/target sampled at edge N are
// visible after edge N.
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W      = 12,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    // Reject unsupported depths at elaboration time.
    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: STACK_DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic              err_next;

    // Modulo 2^ADDR_W; wraps silently, including the pushed return address.
    assign pc_inc = pc + ADDR_W'(1);

`ifdef PC_STACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic [ADDR_W-1:0] stack_top;

    // count_q - 1 addresses the most recent entry; only consumed when the
    // stack is non-empty, so the wrapped index at count 0 is harmless.
    assign stack_top = stack_mem[PTR_W'(count_q - CNT_W'(1))];

    always_comb begin
        pc_next    = pc;
        err_next   = 1'b0;
        count_next = count_q;
        push       = 1'b0;
        if (en) begin
            case (op)
                OP_HOLD: pc_next = pc;
                OP_JMP:  pc_next = target;
                // Same-width two's-complement add equals adding the
                // sign-extended offset modulo 2^ADDR_W.
                OP_BR:   pc_next = pc + target;
                OP_CALL: begin
                    if (count_q == DEPTH_CNT) begin
                        pc_next  = pc_inc;
                        err_next = 1'b1;
                    end else begin
                        pc_next    = target;
                        push       = 1'b1;
                        count_next = count_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (count_q == '0) begin
                        pc_next  = pc_inc;
                        err_next = 1'b1;
                    end else begin
                        pc_next    = stack_top;
                        count_next = count_q - CNT_W'(1);
                    end
                end
                default: pc_next = pc_inc;   // INC and reserved codes
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc          <= RESET_ADDR;
            count_q     <= '0;
            stack_full  <= 1'b0;
            stack_empty <= 1'b1;
            stack_err   <= 1'b0;
        end else begin
            pc          <= pc_next;
            count_q     <= count_next;
            stack_full  <= (count_next == DEPTH_CNT);
            stack_empty <= (count_next == '0);
            stack_err   <= err_next;
        end
    end

    // Entry contents are don't-care after reset, so storage is not cleared.
    // A push never happens when full, so existing entries are never overwritten.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[count_q[PTR_W-1:0]] <= pc_inc;
        end
    end
`else
    always_comb begin
        pc_next  = pc;
        err_next = 1'b0;
        if (en) begin
            case (op)
                OP_HOLD: pc_next = pc;
                OP_JMP:  pc_next = target;
                OP_BR:   pc_next = pc + target;
                OP_CALL: pc_next = target;       // no stack: plain jump
                OP_RET: begin                    // no stack: advance and flag
                    pc_next  = pc_inc;
                    err_next = 1'b1;
                end
                default: pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc        <= RESET_ADDR;
            stack_err <= 1'b0;
        end else begin
            pc        <= pc_next;
            stack_err <= err_next;
        end
    end

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer (ADDR_W=12, STACK_DEPTH=4,
// RESET_ADDR=0). Each scenario task applies a table of vectors, one clock per
// row, and compares pc/stack_err/stack_full/stack_empty against hand-computed
// values. Where the stack and no-stack builds differ, the expected value is
// selected by STK, which follows PC_STACK_EN.
// ============================================================================
module tb_pc_sequencer;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] INC  = 3'b001;
    localparam logic [2:0] JMP  = 3'b010;
    localparam logic [2:0] BR   = 3'b011;
    localparam logic [2:0] CALL = 3'b100;
    localparam logic [2:0] RET  = 3'b101;

`ifdef PC_STACK_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif
    localparam logic NSTK = ~STK;

    typedef struct packed {
        logic        en;
        logic [2:0]  op;
        logic [11:0] tgt;
        logic [11:0] pc;
        logic        err;
        logic        full;
        logic        empty;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic [2:0]  op;
    logic [11:0] target;
    logic [11:0] pc;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W      (12),
        .STACK_DEPTH (4),
        .RESET_ADDR  (12'h000)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .op          (op),
        .target      (target),
        .pc          (pc),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    // ---------------- driver ----------------
    // Inputs change 1 ns after a rising edge; outputs are read at the same point.
    task automatic apply(input vec_t v);
        en     = v.en;
        op     = v.op;
        target = v.tgt;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clr = 1'b0; en = 1'b0; op = HOLD; target = 12'h000;
        #12;
        checks++;
        if (pc !== 12'h000 || stack_err !== 1'b0 || stack_full !== 1'b0 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset pc=%h err=%b full=%b empty=%b expected pc=000 err=0 full=0 empty=1",
                     pc, stack_err, stack_full, stack_empty);
        end
        @(posedge clk); #1;
        clr = 1'b1;
    endtask

    task automatic test_inc_hold();
        vec_t v [8];
        v = '{
            '{1'b1, INC,  12'h000, 12'h001, 1'b0, 1'b0, 1'b1},
            '{1'b1, INC,  12'h000, 12'h002, 1'b0, 1'b0, 1'b1},
            '{1'b1, INC,  12'h000, 12'h003, 1'b0, 1'b0, 1'b1},
            '{1'b1, INC,  12'h000, 12'h004, 1'b0, 1'b0, 1'b1},
            '{1'b1, INC,  12'h000, 12'h005, 1'b0, 1'b0, 1'b1},
            '{1'b0, INC,  12'h000, 12'h005, 1'b0, 1'b0, 1'b1},
            '{1'b0, CALL, 12'h777, 12'h005, 1'b0, 1'b0, 1'b1},
            '{1'b0, JMP,  12'h123, 12'h005, 1'b0, 1'b0, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            apply(v[i]);
            checks++;
            if (pc !== v[i].pc || stack_err !== v[i].err || stack_full !== v[i].full || stack_empty !== v[i].empty) begin
                errors++;
                $display("FAIL inc_hold[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, v[i].pc, v[i].err, v[i].full, v[i].empty);
            end
        end
    endtask

    task automatic test_jump_branch();
        vec_t v [8];
        v = '{
            '{1'b1, JMP,    12'hFFE, 12'hFFE, 1'b0, 1'b0, 1'b1},
            '{1'b1, INC,    12'h000, 12'hFFF, 1'b0, 1'b0, 1'b1},
            '{1'b1, INC,    12'h000, 12'h000, 1'b0, 1'b0, 1'b1},  // wrap
            '{1'b1, BR,     12'hFFD, 12'hFFD, 1'b0, 1'b0, 1'b1},  // -3
            '{1'b1, BR,     12'h005, 12'h002, 1'b0, 1'b0, 1'b1},  // +5 wraps
            '{1'b1, 3'b110, 12'h3AB, 12'h003, 1'b0, 1'b0, 1'b1},  // reserved = INC
            '{1'b1, 3'b111, 12'h3AB, 12'h004, 1'b0, 1'b0, 1'b1},
            '{1'b1, HOLD,   12'h3AB, 12'h004, 1'b0, 1'b0, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            apply(v[i]);
            checks++;
            if (pc !== v[i].pc || stack_err !== v[i].err || stack_full !== v[i].full || stack_empty !== v[i].empty) begin
                errors++;
                $display("FAIL jump_branch[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, v[i].pc, v[i].err, v[i].full, v[i].empty);
            end
        end
    endtask

    task automatic test_call_ret();
        vec_t v [5];
        v = '{
            '{1'b1, JMP,  12'h010, 12'h010,                  1'b0, 1'b0, 1'b1},
            '{1'b1, CALL, 12'h100, 12'h100,                  1'b0, 1'b0, NSTK},
            '{1'b1, CALL, 12'h200, 12'h200,                  1'b0, 1'b0, NSTK},
            '{1'b1, RET,  12'h000, STK ? 12'h101 : 12'h201,  NSTK, 1'b0, NSTK},
            '{1'b1, RET,  12'h000, STK ? 12'h011 : 12'h202,  NSTK, 1'b0, 1'b1}
        };
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            checks++;
            if (pc !== v[i].pc || stack_err !== v[i].err || stack_full !== v[i].full || stack_empty !== v[i].empty) begin
                errors++;
                $display("FAIL call_ret[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, v[i].pc, v[i].err, v[i].full, v[i].empty);
            end
        end
    endtask

    task automatic test_stack_full();
        vec_t v [11];
        v = '{
            '{1'b1, JMP,  12'h020, 12'h020,                 1'b0, 1'b0, 1'b1},
            '{1'b1, CALL, 12'h300, 12'h300,                 1'b0, 1'b0, NSTK},
            '{1'b1, CALL, 12'h300, 12'h300,                 1'b0, 1'b0, NSTK},
            '{1'b1, CALL, 12'h300, 12'h300,                 1'b0, 1'b0, NSTK},
            '{1'b1, CALL, 12'h300, 12'h300,                 1'b0, STK,  NSTK},  // now full
            '{1'b1, CALL, 12'h300, STK ? 12'h301 : 12'h300, STK,  STK,  NSTK},  // overflow
            '{1'b1, RET,  12'h000, 12'h301,                 NSTK, 1'b0, NSTK},
            '{1'b1, RET,  12'h000, STK ? 12'h301 : 12'h302, NSTK, 1'b0, NSTK},
            '{1'b1, RET,  12'h000, STK ? 12'h301 : 12'h303, NSTK, 1'b0, NSTK},
            '{1'b1, RET,  12'h000, STK ? 12'h021 : 12'h304, NSTK, 1'b0, 1'b1},
            '{1'b1, RET,  12'h000, STK ? 12'h022 : 12'h305, 1'b1, 1'b0, 1'b1}   // underflow
        };
        for (int i = 0; i < 11; i++) begin
            apply(v[i]);
            checks++;
            if (pc !== v[i].pc || stack_err !== v[i].err || stack_full !== v[i].full || stack_empty !== v[i].empty) begin
                errors++;
                $display("FAIL stack_full[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, v[i].pc, v[i].err, v[i].full, v[i].empty);
            end
        end
    endtask

    task automatic test_err_pulse();
        vec_t v [6];
        v = '{
            '{1'b1, JMP, 12'h050, 12'h050, 1'b0, 1'b0, 1'b1},
            '{1'b1, RET, 12'h000, 12'h051, 1'b1, 1'b0, 1'b1},
            '{1'b0, RET, 12'h000, 12'h051, 1'b0, 1'b0, 1'b1},  // en=0 clears pulse
            '{1'b1, RET, 12'h000, 12'h052, 1'b1, 1'b0, 1'b1},
            '{1'b1, RET, 12'h000, 12'h053, 1'b1, 1'b0, 1'b1},  // back-to-back error
            '{1'b1, INC, 12'h000, 12'h054, 1'b0, 1'b0, 1'b1}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            checks++;
            if (pc !== v[i].pc || stack_err !== v[i].err || stack_full !== v[i].full || stack_empty !== v[i].empty) begin
                errors++;
                $display("FAIL err_pulse[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, v[i].pc, v[i].err, v[i].full, v[i].empty);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [8];
        v = '{
            '{1'b1, JMP,  12'h7F0, 12'h7F0,                 1'b0, 1'b0, 1'b1},
            '{1'b1, CALL, 12'h123, 12'h123,                 1'b0, 1'b0, NSTK},
            '{1'b0, RET,  12'h000, 12'h123,                 1'b0, 1'b0, NSTK},  // stack holds
            '{1'b1, RET,  12'h000, STK ? 12'h7F1 : 12'h124, NSTK, 1'b0, 1'b1},
            '{1'b1, CALL, 12'hFFF, 12'hFFF,                 1'b0, 1'b0, NSTK},
            '{1'b1, CALL, 12'h0AA, 12'h0AA,                 1'b0, 1'b0, NSTK},  // pushes FFF+1 = 000
            '{1'b1, RET,  12'h000, STK ? 12'h000 : 12'h0AB, NSTK, 1'b0, NSTK},
            '{1'b1, RET,  12'h000, STK ? 12'h7F2 : 12'h0AC, NSTK, 1'b0, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            apply(v[i]);
            checks++;
            if (pc !== v[i].pc || stack_err !== v[i].err || stack_full !== v[i].full || stack_empty !== v[i].empty) begin
                errors++;
                $display("FAIL back_to_back[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, v[i].pc, v[i].err, v[i].full, v[i].empty);
            end
        end
    endtask

    task automatic test_clr_mid();
        vec_t pre [3];
        vec_t post [2];
        pre = '{
            '{1'b1, JMP,  12'h040, 12'h040, 1'b0, 1'b0, 1'b1},
            '{1'b1, CALL, 12'h400, 12'h400, 1'b0, 1'b0, NSTK},
            '{1'b1, CALL, 12'h500, 12'h500, 1'b0, 1'b0, NSTK}   // count 2
        };
        post = '{
            '{1'b1, INC, 12'h000, 12'h001, 1'b0, 1'b0, 1'b1},
            '{1'b1, RET, 12'h000, 12'h002, 1'b1, 1'b0, 1'b1}    // stack really cleared
        };
        for (int i = 0; i < 3; i++) begin
            apply(pre[i]);
            checks++;
            if (pc !== pre[i].pc || stack_err !== pre[i].err || stack_full !== pre[i].full || stack_empty !== pre[i].empty) begin
                errors++;
                $display("FAIL clr_pre[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, pre[i].pc, pre[i].err, pre[i].full, pre[i].empty);
            end
        end
        // Assert clr between edges; outputs must clear without a clock edge.
        en = 1'b0;
        #3 clr = 1'b0;
        #1;
        checks++;
        if (pc !== 12'h000 || stack_err !== 1'b0 || stack_full !== 1'b0 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL clr_async pc=%h err=%b full=%b empty=%b expected pc=000 err=0 full=0 empty=1",
                     pc, stack_err, stack_full, stack_empty);
        end
        #1 clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(post[i]);
            checks++;
            if (pc !== post[i].pc || stack_err !== post[i].err || stack_full !== post[i].full || stack_empty !== post[i].empty) begin
                errors++;
                $display("FAIL clr_post[%0d] pc=%h err=%b full=%b empty=%b expected pc=%h err=%b full=%b empty=%b",
                         i, pc, stack_err, stack_full, stack_empty, post[i].pc, post[i].err, post[i].full, post[i].empty);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_inc_hold();
        test_jump_branch();
        test_call_ret();
        test_stack_full();
        test_err_pulse();
        test_back_to_back();
        test_clr_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
